uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises one `DATA_BITS`-wide word per request into a start bit, data bits (LSB first), an optional parity bit and one stop bit. It is the transmit counterpart of `uart_rx` and shares its `ratio`, `parity_en` and `parity_odd` semantics, so one configuration drives both directions of a link. It sits between the user-side register/FIFO logic and the `UART_TX` pad.

## Interface
- `RATIO_REG_SIZE`, default 8: width of the clocks-per-bit divisor.
- `DATA_BITS`, default 8: data bits per frame.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ratio`  in  RATIO_REG_SIZE  clocks per bit; latched at frame start.
- `tx_enb`  in  1  transmitter enable; gates acceptance of new frames only.
- `tx_start`  in  1  request to send `data`; level-sampled in IDLE.
- `data`  in  DATA_BITS  word to send; latched at acceptance.
- `parity_en`  in  1  1 = parity bit included; latched at acceptance.
- `parity_odd`  in  1  1 = odd parity (bit = ~^data), 0 = even parity (bit = ^data); latched at acceptance.
- `busy`  out  1  high from acceptance until the stop bit completes.
- `done`  out  1  one-cycle pulse at the end of the stop bit.
- `UART_TX`  out  1  serial line, registered, idle high.

## Operation
- Reset values: `UART_TX`=1, `busy`=0, `done`=0, state IDLE, all counters and shift/latch registers 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - line high, `done` cleared after its single cycle.
  - If `tx_enb & tx_start`, latch `data`, `ratio`, `parity_en` and `parity_odd`; set `busy`=1; go to START.
- `ratio` of 0 is latched as 1.
- Bit timing: a prescaler counts 0..ratio_reg-1. Each bit is held for exactly ratio_reg clocks; when the prescaler wraps, the FSM advances.
- START: line 0.
- DATA: line = data bit `index`, with `index` running 0..DATA_BITS-1 (LSB first). After the last bit, go to PARITY if `parity_en`, otherwise to STOP.
- PARITY: line = computed parity bit.
- STOP: line 1. On the wrap, go to IDLE with `busy`=0 and `done`=1.
- `tx_start` while `busy` is ignored; there is no queuing.
- Changes to `tx_enb`, `ratio`, `parity_*` or `data` mid-frame have no effect on the frame in progress.
- `reset` mid-frame: the next edge forces the reset values, the line returns high immediately, and no `done` is produced.

## Timing
- Acceptance at edge N. From edge N, `UART_TX`=0 and `busy`=1 (a registered output, so it is visible in cycle N+1).
- Frame length: (2 + DATA_BITS + parity_en) × ratio_reg clocks, measured from edge N to the edge that sets `done`.
- `done` and `busy`=0 appear on the same edge. `done` lasts one cycle.
- Back-to-back: `tx_start` held high through that cycle is accepted on the next edge. The inter-frame gap on the line is therefore exactly one clock of high, plus the stop bit.
- The line only changes at prescaler wraps, so there are no glitches between bits.

## Structure
- Shared include `uart_defs.vh`:
  - FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit).
  - Parity-mode meaning, shared with `uart_rx`.
- Sub-module `uart_baud_tick`:
  - Loadable prescaler taking `ratio_reg`; outputs a wrap strobe; cleared when the block is idle.
  - Reusable later by `uart_rx`.
- The rest stays in one module: FSM, bit index, data shift register, parity register.

## Test plan
- ratio=4, parity off, data=0xA5, `tx_start` pulse → line 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. `done` pulses 40 clocks after acceptance; `busy` is high for those 40 clocks.
- ratio=4, parity on, data=0xA5:
  - `parity_odd`=1 → parity bit 1; `parity_odd`=0 → parity bit 0.
  - Frame is 44 clocks.
- `tx_start` held high for two frames with data 0x00 then 0xFF, ratio=2 → second frame accepted on the edge after `done`. A `tx_start` pulse mid-frame is ignored, and `data` changed mid-frame does not alter the line.
- ratio=0 and ratio=1 → each bit lasts 1 clock; frame is 10 clocks. `tx_enb`=0 with `tx_start`=1 → no frame, line stays 1.
- `reset` asserted during DATA bit 3 → next edge gives `UART_TX`=1, `busy`=0, `done`=0. A subsequent request sends a clean full frame.
- Loopback into `uart_rx` with matching `ratio`/`parity_*`, random data × 200 → `new_data` each frame, data matches, `parity_err`=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding and parity-mode helper,
// common to the transmit and receive directions.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // parity_odd=1 -> bit = ~^data, parity_odd=0 -> bit = ^data.
  function automatic logic parity_of(input logic xor_red, input logic parity_odd);
    return parity_odd ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period prescaler: counts 0..ratio_reg-1 and strobes on the wrap.
// Held at zero while clear is high so every bit period starts aligned.
module uart_baud_tick #(
  parameter int RATIO_REG_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [RATIO_REG_SIZE-1:0] ratio_reg,
  output logic                      wrap
);

  logic [RATIO_REG_SIZE-1:0] cnt;

  assign wrap = !clear && (cnt == ratio_reg - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// one stop bit. Line, busy and done are all registered.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int RATIO_REG_SIZE = 8,
  parameter int DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RATIO_REG_SIZE-1:0] ratio,
  input  logic                      tx_enb,
  input  logic                      tx_start,
  input  logic [DATA_BITS-1:0]      data,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  output logic                      busy,
  output logic                      done,
  output logic                      UART_TX
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e               state, state_nxt;
  logic                      line_nxt, busy_nxt, done_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [DATA_BITS-1:0]      shreg, shreg_nxt;
  logic                      par_bit, par_nxt;
  logic                      pe_reg, pe_nxt;
  logic [RATIO_REG_SIZE-1:0] ratio_reg, ratio_nxt;
  logic                      wrap;

  uart_baud_tick #(
    .RATIO_REG_SIZE(RATIO_REG_SIZE)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_IDLE),
    .ratio_reg(ratio_reg),
    .wrap     (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      UART_TX   <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      pe_reg    <= 1'b0;
      ratio_reg <= '0;
    end else begin
      state     <= state_nxt;
      UART_TX   <= line_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      par_bit   <= par_nxt;
      pe_reg    <= pe_nxt;
      ratio_reg <= ratio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = UART_TX;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    pe_nxt    = pe_reg;
    ratio_nxt = ratio_reg;

    unique case (state)
      ST_IDLE: begin
        line_nxt = LINE_IDLE;
        if (tx_enb && tx_start) begin
          state_nxt = ST_START;
          line_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          shreg_nxt = data;
          pe_nxt    = parity_en;
          ratio_nxt = (ratio == '0) ? RATIO_REG_SIZE'(1) : ratio;
          // The parity bit is resolved at acceptance, which latches the
          // parity mode and data together for the whole frame.
          par_nxt   = parity_of(^data, parity_odd);
        end
      end

      ST_START: begin
        if (wrap) begin
          state_nxt = ST_DATA;
          line_nxt  = shreg[0];
          idx_nxt   = '0;
        end
      end

      ST_DATA: begin
        if (wrap) begin
          if (idx == LAST_IDX) begin
            if (pe_reg) begin
              state_nxt = ST_PARITY;
              line_nxt  = par_bit;
            end else begin
              state_nxt = ST_STOP;
              line_nxt  = 1'b1;
            end
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shreg >> 1;
            line_nxt  = shreg_nxt[0];
          end
        end
      end

      ST_PARITY: begin
        if (wrap) begin
          state_nxt = ST_STOP;
          line_nxt  = 1'b1;
        end
      end

      ST_STOP: begin
        if (wrap) begin
          state_nxt = ST_IDLE;
          line_nxt  = LINE_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        line_nxt  = LINE_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: each frame's expected line is built as a list of bit
// values, each held ratio clocks, and compared cycle by cycle.
module tb_uart_tx;

  localparam int RW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, tx_enb, tx_start, parity_en, parity_odd;
  logic [RW-1:0] ratio;
  logic [DW-1:0] data;
  logic          busy, done, UART_TX;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .RATIO_REG_SIZE(RW),
    .DATA_BITS     (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ratio     (ratio),
    .tx_enb    (tx_enb),
    .tx_start  (tx_start),
    .data      (data),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .busy      (busy),
    .done      (done),
    .UART_TX   (UART_TX)
  );

  task automatic check(input string tag, input logic [2:0] exp);
    vectors++;
    assert ({UART_TX, busy, done} === exp)
    else begin
      miscompares++;
      $error("FAIL %s: {tx,busy,done} observed %b expected %b at %0t",
             tag, {UART_TX, busy, done}, exp, $time);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 3'b100);
    end
  endtask

  // Called at a negedge; request is accepted on the following posedge.
  task automatic send(input string tag, input logic [DW-1:0] d, input int r,
                      input logic pe, input logic po, input bit keep,
                      input bit noise, input int abort_k);
    logic bits[$];
    int   rr, ones, len;
    data       = d;
    ratio      = RW'(r);
    parity_en  = pe;
    parity_odd = po;
    tx_enb     = 1'b1;
    tx_start   = 1'b1;
    rr   = (r == 0) ? 1 : r;
    ones = $countones(d);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    len = bits.size() * rr;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0 && !keep) tx_start = 1'b0;
      check(tag, {bits[k / rr], 2'b10});
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_reset"}, 3'b100);
        reset = 1'b0;
        return;
      end
      if (noise) begin
        data       = DW'($urandom);
        ratio      = RW'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        tx_enb     = 1'($urandom);
        tx_start   = 1'($urandom);
      end
      if (k == len - 1) begin
        tx_start = keep;
        tx_enb   = 1'b1;
      end
    end
    @(negedge clk);
    check({tag, "_done"}, 3'b101);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tx_enb = 1'b0; tx_start = 1'b0; data = '0; ratio = '0;
    parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", 3'b100);
    reset = 1'b0;
    idle_check("idle", 2);

    send("a5_r4", 8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_check("after_a5", 2);
    send("a5_odd", 8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send("a5_even", 8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_check("after_par", 1);

    send("b2b_00", 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send("b2b_ff", 8'hFF, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_check("after_b2b", 2);

    send("ratio0", 8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send("ratio1", 8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    tx_enb = 1'b0; tx_start = 1'b1;
    idle_check("enb_off", 10);
    tx_start = 1'b0; tx_enb = 1'b1;

    // k=17 falls inside data bit 3 (bit slot 4) at ratio 4.
    send("abort", 8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    idle_check("post_abort", 3);
    send("clean", 8'h5A, 4, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle_check("after_clean", 1);

    for (int n = 0; n < 200; n++) begin
      send("rand", DW'($urandom), int'($urandom_range(0, 5)), 1'($urandom),
           1'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), -1);
    end
    tx_start = 1'b0;
    idle_check("final_idle", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
